// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready command stream to pipelined zero-wait-state transfers.
// Optional build macro AHB_MASTER_ERR_HALT_EN: halt command acceptance after an errored response.
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  err_clear,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  hsel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hsize,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hresp
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  function automatic logic is_misaligned(input logic size, input logic [ADDR_WIDTH-1:0] addr);
    return size & addr[0];
  endfunction

  state_t                state_r, state_nxt_s;
  logic                  accept_s, cmd_mis_s;
  logic                  ap_valid_r, ap_write_r, ap_mis_r;
  logic [ADDR_WIDTH-1:0] ap_addr_r;
  logic [DATA_WIDTH-1:0] ap_wdata_r;
  logic                  dp_valid_r, dp_write_r, dp_mis_r;
  logic [ADDR_WIDTH-1:0] dp_addr_r;
  logic                  dp_issued_s, dp_err_s;
  logic [DATA_WIDTH-1:0] dp_rdata_s;

  assign cmd_ready   = (state_r == ST_RUN);
  assign accept_s    = cmd_valid & cmd_ready;
  assign cmd_mis_s   = is_misaligned(cmd_size, cmd_addr);
  assign busy        = ap_valid_r | dp_valid_r;
  // A misaligned slot never reaches the bus, so hresp/hrdata are meaningless for it.
  assign dp_issued_s = dp_valid_r & ~dp_mis_r;
  assign dp_err_s    = dp_mis_r | (dp_issued_s & hresp);
  assign dp_rdata_s  = (dp_issued_s && !dp_write_r && !hresp) ? hrdata : {DATA_WIDTH{1'b0}};

  // Address-phase slot and registered bus address-phase outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ap_valid_r <= 1'b0;
      ap_write_r <= 1'b0;
      ap_mis_r   <= 1'b0;
      ap_addr_r  <= {ADDR_WIDTH{1'b0}};
      ap_wdata_r <= {DATA_WIDTH{1'b0}};
      hsel       <= 1'b0;
      htrans     <= HTRANS_IDLE;
      haddr      <= {ADDR_WIDTH{1'b0}};
      hsize      <= 1'b0;
      hwrite     <= 1'b0;
    end else if (accept_s) begin
      ap_valid_r <= 1'b1;
      ap_write_r <= cmd_write;
      ap_mis_r   <= cmd_mis_s;
      ap_addr_r  <= cmd_addr;
      ap_wdata_r <= cmd_wdata;
      hsel       <= ~cmd_mis_s;
      htrans     <= cmd_mis_s ? HTRANS_IDLE : HTRANS_NONSEQ;
      haddr      <= cmd_mis_s ? {ADDR_WIDTH{1'b0}} : cmd_addr;
      hsize      <= cmd_mis_s ? 1'b0 : cmd_size;
      hwrite     <= cmd_mis_s ? 1'b0 : cmd_write;
    end else begin
      ap_valid_r <= 1'b0;
      ap_mis_r   <= 1'b0;
      hsel       <= 1'b0;
      htrans     <= HTRANS_IDLE;
      haddr      <= {ADDR_WIDTH{1'b0}};
      hsize      <= 1'b0;
      hwrite     <= 1'b0;
    end
  end

  // Data-phase slot; hwdata only changes for an issued write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_mis_r   <= 1'b0;
      dp_addr_r  <= {ADDR_WIDTH{1'b0}};
      hwdata     <= {DATA_WIDTH{1'b0}};
    end else begin
      dp_valid_r <= ap_valid_r;
      dp_write_r <= ap_write_r;
      dp_mis_r   <= ap_mis_r;
      dp_addr_r  <= ap_addr_r;
      if (ap_valid_r && !ap_mis_r && ap_write_r) begin
        hwdata <= ap_wdata_r;
      end
    end
  end

  // Response register: one pulse per completed data phase.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_addr  <= {ADDR_WIDTH{1'b0}};
      rsp_rdata <= {DATA_WIDTH{1'b0}};
      rsp_error <= 1'b0;
    end else if (dp_valid_r) begin
      rsp_valid <= 1'b1;
      rsp_write <= dp_write_r;
      rsp_addr  <= dp_addr_r;
      rsp_rdata <= dp_rdata_s;
      rsp_error <= dp_err_s;
    end else begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_addr  <= {ADDR_WIDTH{1'b0}};
      rsp_rdata <= {DATA_WIDTH{1'b0}};
      rsp_error <= 1'b0;
    end
  end

  // Run/halt state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef AHB_MASTER_ERR_HALT_EN
  // Halt on the edge an errored response is registered; a new error outranks err_clear.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (dp_valid_r && dp_err_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (err_clear && !(dp_valid_r && dp_err_s)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end
`else
  logic unused_err_clear_s;
  assign unused_err_clear_s = err_clear;

  // Without halting, the master always runs.
  always_comb begin
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_RUN;
    endcase
  end
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master with a small zero-wait AHB-Lite slave model.
module tb_ahb_lite_master;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_size = 1'b0, err_clear = 1'b0;
  logic [3:0]  cmd_addr = 4'h0;
  logic [15:0] cmd_wdata = 16'h0000;
  logic        cmd_ready, rsp_valid, rsp_write, rsp_error, busy, hsel, hsize, hwrite, hresp;
  logic [3:0]  rsp_addr, haddr;
  logic [15:0] rsp_rdata, hwdata, hrdata;
  logic [1:0]  htrans;

  int total = 0;
  int bad = 0;

  // Slave model: read data = 0x00A9 + addr, error on writes to 0x0, garbage when unselected.
  logic       s_sel = 1'b0, s_wr = 1'b0;
  logic [3:0] s_addr = 4'h0;
  always @(posedge clk) begin
    s_sel  <= hsel & htrans[1];
    s_addr <= haddr;
    s_wr   <= hwrite;
  end
  assign hresp  = s_sel & s_wr & (s_addr == 4'h0);
  assign hrdata = (s_sel && !s_wr) ? (16'h00A9 + {12'h000, s_addr}) : 16'hFFFF;

  ahb_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata), .err_clear(err_clear),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
    .hsel(hsel), .haddr(haddr), .hsize(hsize), .htrans(htrans), .hwrite(hwrite),
    .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [3:0] addr, input logic sz, input logic [15:0] wd);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = sz;
    cmd_wdata = wd;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_hsel", hsel, 0);
    check("rst_htrans", htrans, 0);
    check("rst_haddr", haddr, 0);
    check("rst_hwdata", hwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    tick();
    n_rst = 1'b1;
    tick();

    // Single write 0x4 halfword 0x1234
    drive(1'b1, 4'h4, 1'b1, 16'h1234);
    tick();
    cmd_valid = 1'b0;
    check("wr_hsel", hsel, 1);
    check("wr_htrans", htrans, 2);
    check("wr_haddr", haddr, 4);
    check("wr_hwrite", hwrite, 1);
    check("wr_hsize", hsize, 1);
    check("wr_busy", busy, 1);
    tick();
    check("wr_hwdata", hwdata, 16'h1234);
    check("wr_dp_htrans_idle", htrans, 0);
    tick();
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_error", rsp_error, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_write", rsp_write, 1);
    check("wr_rsp_addr", rsp_addr, 4);
    tick();
    check("wr_rsp_done", rsp_valid, 0);
    check("wr_busy_done", busy, 0);

    // Write 0x4 then read 0x2 back-to-back
    drive(1'b1, 4'h4, 1'b1, 16'h5555);
    tick();
    drive(1'b0, 4'h2, 1'b1, 16'h0000);
    check("b2b_w_haddr", haddr, 4);
    tick();
    cmd_valid = 1'b0;
    check("b2b_r_haddr", haddr, 2);
    check("b2b_r_hwrite", hwrite, 0);
    check("b2b_w_hwdata", hwdata, 16'h5555);
    tick();
    check("b2b_w_rsp_valid", rsp_valid, 1);
    check("b2b_w_rsp_write", rsp_write, 1);
    check("b2b_hwdata_hold", hwdata, 16'h5555);
    tick();
    check("b2b_r_rsp_valid", rsp_valid, 1);
    check("b2b_r_rsp_write", rsp_write, 0);
    check("b2b_r_rsp_addr", rsp_addr, 2);
    check("b2b_r_rsp_rdata", rsp_rdata, 16'h00AB);
    check("b2b_r_rsp_error", rsp_error, 0);
    tick();

    // Misaligned halfword read at 0x3
    drive(1'b0, 4'h3, 1'b1, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    check("mis_hsel", hsel, 0);
    check("mis_htrans", htrans, 0);
    check("mis_busy", busy, 1);
    tick();
    check("mis_busy_dp", busy, 1);
    tick();
    check("mis_rsp_valid", rsp_valid, 1);
    check("mis_rsp_error", rsp_error, 1);
    check("mis_rsp_rdata", rsp_rdata, 0);
    check("mis_rsp_addr", rsp_addr, 3);
    tick();

    // Slave error on write to 0x0 with a read queued behind it
    drive(1'b1, 4'h0, 1'b1, 16'h7777);
    tick();
    drive(1'b0, 4'h2, 1'b1, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_error", rsp_error, 1);
    check("err_rsp_rdata", rsp_rdata, 0);
`ifdef AHB_MASTER_ERR_HALT_EN
    check("err_cmd_ready_halt", cmd_ready, 0);
`else
    check("err_cmd_ready_run", cmd_ready, 1);
`endif
    tick();
    check("err_q_rsp_valid", rsp_valid, 1);
    check("err_q_rsp_error", rsp_error, 0);
    check("err_q_rsp_rdata", rsp_rdata, 16'h00AB);
`ifdef AHB_MASTER_ERR_HALT_EN
    check("err_still_halt", cmd_ready, 0);
`else
    check("err_still_run", cmd_ready, 1);
`endif
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("err_clear_ready", cmd_ready, 1);

    // Three back-to-back reads, reset during the second address phase
    drive(1'b0, 4'h2, 1'b1, 16'h0000);
    tick();
    drive(1'b0, 4'h4, 1'b1, 16'h0000);
    tick();
    drive(1'b0, 4'h6, 1'b1, 16'h0000);
    check("rst_mid_hsel_pre", hsel, 1);
    n_rst = 1'b0;
    #1;
    cmd_valid = 1'b0;
    check("rst_mid_hsel", hsel, 0);
    check("rst_mid_htrans", htrans, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hwdata", hwdata, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_no_rsp", rsp_valid, 0);
    end
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rel_no_rsp", rsp_valid, 0);
    end
    drive(1'b0, 4'h8, 1'b1, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    check("post_rst_haddr", haddr, 8);
    tick();
    check("post_rst_rsp_early", rsp_valid, 0);
    tick();
    check("post_rst_rsp_valid", rsp_valid, 1);
    check("post_rst_rsp_rdata", rsp_rdata, 16'h00B1);

    // Idle stream
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 1) begin
        check("idle_htrans", htrans, 0);
        check("idle_hsel", hsel, 0);
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
